// File: rtl/mem_pkg.sv
// Shared types for the coherent shared memory: coherency states and the
// controller FSM encoding. No ports.
package mem_pkg;

   // Encodings are fixed because they appear on resp_state.
   typedef enum logic [1:0] {
      I = 2'b00,
      M = 2'b01,
      S = 2'b10
   } coherency_t;

   typedef enum logic [1:0] {
      INIT   = 2'b00,
      IDLE   = 2'b01,
      ACCESS = 2'b10,
      RESP   = 2'b11
   } fsm_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above
// ptr_i, wrapping modulo NUM_PROCS.
//   req_i  request vector
//   ptr_i  highest-priority index
//   gnt_o  one-hot grant (zero when no request)
//   idx_o  index of the granted requester (zero when no request)
module rr_arbiter #(
   parameter int unsigned NUM_PROCS = 4
) (
   input  logic [NUM_PROCS-1:0]         req_i,
   input  logic [$clog2(NUM_PROCS)-1:0] ptr_i,
   output logic [NUM_PROCS-1:0]         gnt_o,
   output logic [$clog2(NUM_PROCS)-1:0] idx_o
);

   localparam int unsigned IDX_W = $clog2(NUM_PROCS);

   // Scan NUM_PROCS positions starting at the pointer; first hit wins.
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] cand;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_PROCS; i++) begin
         cand = IDX_W'((32'(ptr_i) + i) % NUM_PROCS);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/coherent_shared_mem.sv
// N-port write-through shared memory with round-robin arbitration and a
// per-line MSI directory that emits invalidation masks on writes.
//   clk, reset_n            clock, synchronous active-low reset
//   req_valid/write/addr/wdata  per-processor request channel (packed)
//   req_ready               one-hot grant, combinational, IDLE only
//   resp_valid/rdata/state  one-cycle completion pulse, read data, new line state
//   inv_valid/inv_mask      one-cycle invalidate pulse and target caches
//   init_done               set once the post-reset line sweep completes
module coherent_shared_mem
   import mem_pkg::*;
#(
   parameter int unsigned NUM_PROCS = 4,
   parameter int unsigned ADDR_W    = 13,
   parameter int unsigned DATA_W    = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_PROCS-1:0]          req_valid,
   input  logic [NUM_PROCS-1:0]          req_write,
   input  logic [NUM_PROCS*ADDR_W-1:0]   req_addr,
   input  logic [NUM_PROCS*DATA_W-1:0]   req_wdata,
   output logic [NUM_PROCS-1:0]          req_ready,
   output logic [NUM_PROCS-1:0]          resp_valid,
   output logic [DATA_W-1:0]             resp_rdata,
   output logic [1:0]                    resp_state,
   output logic                          inv_valid,
   output logic [NUM_PROCS-1:0]          inv_mask,
   output logic                          init_done
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned IDX_W = $clog2(NUM_PROCS);

   typedef struct packed {
      coherency_t           state;
      logic [IDX_W-1:0]     owner;
      logic [NUM_PROCS-1:0] sharers;
   } dir_entry_t;

   // Separate arrays so the data store can map onto block RAM.
   logic [DATA_W-1:0] data_mem [DEPTH];
   dir_entry_t        dir_mem  [DEPTH];

   fsm_t                 state_q, state_d;
   logic [ADDR_W-1:0]    init_idx_q, init_idx_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
   logic                 wr_q, wr_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [NUM_PROCS-1:0] resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]    resp_rdata_q, resp_rdata_d;
   coherency_t           resp_state_q, resp_state_d;
   logic                 inv_valid_q, inv_valid_d;
   logic [NUM_PROCS-1:0] inv_mask_q, inv_mask_d;
   logic                 init_done_q, init_done_d;

   logic                 mem_we, dir_we;
   logic [ADDR_W-1:0]    mem_addr;
   logic [DATA_W-1:0]    mem_wdata;
   dir_entry_t           dir_wentry;
   dir_entry_t           old_e, new_e;
   logic [NUM_PROCS-1:0] gbit, obit, inv_c;
   logic [NUM_PROCS-1:0] arb_gnt;
   logic [IDX_W-1:0]     arb_idx;

   logic [ADDR_W-1:0]    addr_arr  [NUM_PROCS];
   logic [DATA_W-1:0]    wdata_arr [NUM_PROCS];

   // Unpack the per-processor request fields.
   for (genvar p = 0; p < NUM_PROCS; p++) begin : g_unpack
      assign addr_arr[p]  = req_addr[p*ADDR_W +: ADDR_W];
      assign wdata_arr[p] = req_wdata[p*DATA_W +: DATA_W];
   end

   rr_arbiter #(.NUM_PROCS(NUM_PROCS)) u_arb (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   assign req_ready = (state_q == IDLE) ? arb_gnt : '0;

   // Directory update for the captured request. Invalidations are only
   // raised by writes; a read of an M line just demotes the owner to S.
   always_comb begin
      old_e = dir_mem[addr_q];
      new_e = old_e;
      gbit  = NUM_PROCS'(1) << gnt_idx_q;
      obit  = NUM_PROCS'(1) << old_e.owner;
      inv_c = '0;
      if (wr_q) begin
         new_e.state   = M;
         new_e.owner   = gnt_idx_q;
         new_e.sharers = gbit;
         if (old_e.state == S)
            inv_c = old_e.sharers & ~gbit;
         else if (old_e.state == M && old_e.owner != gnt_idx_q)
            inv_c = obit;
      end else if (old_e.state == M) begin
         if (old_e.owner != gnt_idx_q) begin
            new_e.state   = S;
            new_e.sharers = obit | gbit;
         end
      end else begin
         new_e.state   = S;
         new_e.sharers = old_e.sharers | gbit;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d      = state_q;
      init_idx_d   = init_idx_q;
      rr_ptr_d     = rr_ptr_q;
      gnt_idx_d    = gnt_idx_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      init_done_d  = init_done_q;
      resp_valid_d = '0;
      resp_rdata_d = '0;
      resp_state_d = I;
      inv_valid_d  = 1'b0;
      inv_mask_d   = '0;
      mem_we       = 1'b0;
      dir_we       = 1'b0;
      mem_addr     = addr_q;
      mem_wdata    = wdata_q;
      dir_wentry   = '{state: I, owner: '0, sharers: '0};
      case (state_q)
         INIT: begin
            mem_we     = 1'b1;
            dir_we     = 1'b1;
            mem_addr   = init_idx_q;
            mem_wdata  = '0;
            init_idx_d = init_idx_q + ADDR_W'(1);
            if (init_idx_q == ADDR_W'(DEPTH - 1)) begin
               state_d     = IDLE;
               init_done_d = 1'b1;
            end
         end
         IDLE: begin
            if (|req_valid) begin
               gnt_idx_d = arb_idx;
               wr_d      = req_write[arb_idx];
               addr_d    = addr_arr[arb_idx];
               wdata_d   = wdata_arr[arb_idx];
               rr_ptr_d  = (arb_idx == IDX_W'(NUM_PROCS - 1)) ? '0 : arb_idx + IDX_W'(1);
               state_d   = ACCESS;
            end
         end
         ACCESS: begin
            mem_we       = wr_q;
            dir_we       = 1'b1;
            dir_wentry   = new_e;
            resp_valid_d = gbit;
            resp_rdata_d = wr_q ? '0 : data_mem[addr_q];
            resp_state_d = new_e.state;
            inv_mask_d   = inv_c;
            inv_valid_d  = |inv_c;
            state_d      = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = INIT;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= INIT;
         init_idx_q   <= '0;
         rr_ptr_q     <= '0;
         gnt_idx_q    <= '0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_valid_q <= '0;
         resp_rdata_q <= '0;
         resp_state_q <= I;
         inv_valid_q  <= 1'b0;
         inv_mask_q   <= '0;
         init_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         rr_ptr_q     <= rr_ptr_d;
         gnt_idx_q    <= gnt_idx_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_state_q <= resp_state_d;
         inv_valid_q  <= inv_valid_d;
         inv_mask_q   <= inv_mask_d;
         init_done_q  <= init_done_d;
      end
   end

   // Array writes; an access cut short by reset must not land.
   always_ff @(posedge clk) begin
      if (reset_n && mem_we) data_mem[mem_addr] <= mem_wdata;
      if (reset_n && dir_we) dir_mem[mem_addr]  <= dir_wentry;
   end

   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_state = resp_state_q;
   assign inv_valid  = inv_valid_q;
   assign inv_mask   = inv_mask_q;
   assign init_done  = init_done_q;

endmodule

// File: tb/tb_coherent_shared_mem.sv
// Testbench for coherent_shared_mem with NUM_PROCS=4, ADDR_W=4, DATA_W=16.
module tb_coherent_shared_mem;
   import mem_pkg::*;

   localparam int unsigned NP    = 4;
   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 16;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [NP-1:0]    req_valid = '0;
   logic [NP-1:0]    req_write = '0;
   logic [NP*AW-1:0] req_addr = '0;
   logic [NP*DW-1:0] req_wdata = '0;
   logic [NP-1:0]    req_ready;
   logic [NP-1:0]    resp_valid;
   logic [DW-1:0]    resp_rdata;
   logic [1:0]       resp_state;
   logic             inv_valid;
   logic [NP-1:0]    inv_mask;
   logic             init_done;

   coherent_shared_mem #(.NUM_PROCS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_state (resp_state),
      .inv_valid  (inv_valid),
      .inv_mask   (inv_mask),
      .init_done  (init_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            proc;
      logic [DW-1:0] rdata;
      logic [1:0]    st;
      logic          iv;
      logic [NP-1:0] im;
      int            due;
   } exp_t;

   exp_t sb[$];
   int   grant_log[$];

   // Reference model of the memory and directory.
   logic [DW-1:0] m_data [DEPTH];
   logic [1:0]    m_st   [DEPTH];
   int            m_own  [DEPTH];
   logic [NP-1:0] m_sh   [DEPTH];

   logic [DW-1:0] last_rdata;
   logic [1:0]    last_state;
   logic [NP-1:0] last_inv_mask;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_data[i] = '0;
         m_st[i]   = I;
         m_own[i]  = 0;
         m_sh[i]   = '0;
      end
   endfunction

   // Predict the response for the request of processor p granted this cycle.
   function automatic void model_push(input int p);
      exp_t          e;
      logic [AW-1:0] a;
      logic [NP-1:0] gb;
      a      = req_addr[p*AW +: AW];
      gb     = NP'(1) << p;
      e.proc = p;
      e.due  = cyc + 2;
      e.im   = '0;
      if (req_write[p]) begin
         if (m_st[a] == S)
            e.im = m_sh[a] & ~gb;
         else if (m_st[a] == M && m_own[a] != p)
            e.im = NP'(1) << m_own[a];
         m_data[a] = req_wdata[p*DW +: DW];
         m_st[a]   = M;
         m_own[a]  = p;
         m_sh[a]   = gb;
         e.rdata   = '0;
      end else begin
         e.rdata = m_data[a];
         if (m_st[a] == M) begin
            if (m_own[a] != p) begin
               m_st[a] = S;
               m_sh[a] = (NP'(1) << m_own[a]) | gb;
            end
         end else begin
            m_st[a] = S;
            m_sh[a] = m_sh[a] | gb;
         end
      end
      e.st = m_st[a];
      e.iv = |e.im;
      sb.push_back(e);
   endfunction

   task automatic set_req(input int p, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[p]          = 1'b1;
      req_write[p]          = wr;
      req_addr[p*AW +: AW]  = a;
      req_wdata[p*DW +: DW] = d;
   endtask

   task automatic sample_outputs();
      exp_t e;
      if (resp_valid != 0) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", 32'(resp_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("resp_valid", 32'(resp_valid), 32'(NP'(1) << e.proc));
            chk("resp_latency", cyc, e.due);
            chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
            chk("resp_state", 32'(resp_state), 32'(e.st));
            chk("inv_valid", 32'(inv_valid), 32'(e.iv));
            chk("inv_mask", 32'(inv_mask), 32'(e.im));
            last_rdata    = resp_rdata;
            last_state    = resp_state;
            last_inv_mask = inv_mask;
         end
      end else begin
         chk("idle_outputs", {11'd0, inv_valid, inv_mask, resp_rdata}, 32'd0);
      end
   endtask

   // Serve pending requests until all are granted and answered. Processor
   // rearm_p keeps its request up after its first grant.
   task automatic serve(input int rearm_p, input int max_cyc);
      int n = 0;
      bit rearmed = 1'b0;
      bit got;
      int gp = 0;
      while ((req_valid != 0 || sb.size() != 0) && n < max_cyc) begin
         #1;
         sample_outputs();
         got = 1'b0;
         if (req_ready != 0) begin
            chk("ready_onehot", $countones(req_ready), 1);
            chk("ready_subset", 32'(req_ready & ~req_valid), 32'd0);
            for (int p = 0; p < NP; p++)
               if (req_ready[p]) gp = p;
            model_push(gp);
            grant_log.push_back(gp);
            got = 1'b1;
         end
         @(posedge clk);
         #1;
         if (got) begin
            if (gp == rearm_p && !rearmed) rearmed = 1'b1;
            else req_valid[gp] = 1'b0;
         end
         n++;
      end
      chk("serve_timeout", 32'(req_valid != 0 || sb.size() != 0), 32'd0);
   endtask

   task automatic wait_sweep(input string tag);
      int rel;
      int n = 0;
      rel = cyc;
      while (!init_done && n < 40) begin
         #1;
         chk("ready_in_sweep", 32'(req_ready), 32'd0);
         chk("resp_in_sweep", 32'(resp_valid), 32'd0);
         @(posedge clk);
         #1;
         n++;
      end
      chk(tag, cyc - rel, DEPTH);
   endtask

   initial begin
      int n;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
      chk("rst_resp_state", 32'(resp_state), 32'(I));
      chk("rst_inv_valid", 32'(inv_valid), 32'd0);
      chk("rst_inv_mask", 32'(inv_mask), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      @(posedge clk);
      #1;

      // Sweep with a read already pending, then read an untouched line.
      set_req(0, 1'b0, 4'd7, 16'h0000);
      reset_n = 1'b1;
      wait_sweep("sweep_len");
      serve(-1, 20);
      chk("sweep_read_data", 32'(last_rdata), 32'd0);
      chk("sweep_read_state", 32'(last_state), 32'(S));

      // Sharing on addr 3, then a write that invalidates the sharers.
      set_req(0, 1'b1, 4'd3, 16'hBEEF); serve(-1, 20);
      chk("p0_wr3_state", 32'(last_state), 32'(M));
      set_req(1, 1'b0, 4'd3, 16'h0000); serve(-1, 20);
      chk("p1_rd3_data", 32'(last_rdata), 32'hBEEF);
      chk("p1_rd3_state", 32'(last_state), 32'(S));
      set_req(2, 1'b0, 4'd3, 16'h0000); serve(-1, 20);
      chk("p2_rd3_data", 32'(last_rdata), 32'hBEEF);
      set_req(3, 1'b1, 4'd3, 16'h1234); serve(-1, 20);
      chk("p3_wr3_inv_mask", 32'(last_inv_mask), 32'h7);
      chk("p3_wr3_state", 32'(last_state), 32'(M));

      // Read of an M line, then a write by a third processor.
      set_req(0, 1'b1, 4'd5, 16'h5A5A); serve(-1, 20);
      set_req(2, 1'b0, 4'd5, 16'h0000); serve(-1, 20);
      chk("p2_rd5_state", 32'(last_state), 32'(S));
      chk("p2_rd5_no_inv", 32'(last_inv_mask), 32'd0);
      set_req(1, 1'b1, 4'd5, 16'h0F0F); serve(-1, 20);
      chk("p1_wr5_inv_mask", 32'(last_inv_mask), 32'h5);
      set_req(3, 1'b0, 4'd3, 16'h0000); serve(-1, 20);
      chk("p3_rd3_data", 32'(last_rdata), 32'h1234);

      // After the P3 grant rr_ptr is 0; P1 then P3 leaves it at 0 again.
      // Move it to 2 with a P1 grant, then request from P1 and P3.
      set_req(1, 1'b0, 4'd1, 16'h0000); serve(-1, 20);
      grant_log.delete();
      set_req(1, 1'b0, 4'd1, 16'h0000);
      set_req(3, 1'b0, 4'd2, 16'h0000);
      serve(-1, 40);
      chk("rr13_count", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
         chk("rr13_first", grant_log[0], 3);
         chk("rr13_second", grant_log[1], 1);
      end

      // P3 grant returns rr_ptr to 0, then all four contend.
      set_req(3, 1'b0, 4'd4, 16'h0000); serve(-1, 20);
      grant_log.delete();
      for (int p = 0; p < NP; p++) set_req(p, 1'b0, 4'(8 + p), 16'h0000);
      serve(0, 60);
      chk("rr_all_count", grant_log.size(), 5);
      if (grant_log.size() == 5) begin
         for (int k = 0; k < 5; k++) chk("rr_all_order", grant_log[k], k % 4);
      end

      // Reset during ACCESS drops the write and restarts the sweep.
      set_req(2, 1'b1, 4'd9, 16'hA5A5);
      n = 0;
      #1;
      while (!req_ready[2] && n < 10) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("midrst_grant", 32'(req_ready[2]), 32'd1);
      @(posedge clk);
      #1;
      req_valid = '0;
      reset_n   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #2;
         chk("midrst_no_resp", 32'(resp_valid), 32'd0);
         chk("midrst_init_done", 32'(init_done), 32'd0);
      end
      @(posedge clk);
      #1;
      model_reset();
      reset_n = 1'b1;
      wait_sweep("midrst_sweep_len");
      set_req(2, 1'b0, 4'd9, 16'h0000); serve(-1, 20);
      chk("midrst_read_data", 32'(last_rdata), 32'd0);
      chk("midrst_read_state", 32'(last_state), 32'(S));
      set_req(0, 1'b0, 4'd3, 16'h0000); serve(-1, 20);
      chk("midrst_old_line", 32'(last_rdata), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
